// File: rtl/mux1hot_rr_arb.sv
// Round-robin arbiter feeding a one-hot AND-OR mux into a single registered output slot.
// Optional packet lock (in_last/out_last) is enabled by defining MUX1HOT_RR_ARB_PKT_LOCK_EN.
module mux1hot_rr_arb #(
    parameter int N     = 3,
    parameter int WIDTH = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
`ifdef MUX1HOT_RR_ARB_PKT_LOCK_EN
    input  logic [N-1:0]       in_last,
    output logic               out_last,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [N-1:0]       out_grant
);
    // Handshake: a beat transfers on any cycle where valid and ready are both high;
    // valid must not depend on ready, and the slot refills in the same cycle it drains.

    localparam logic [N-1:0] PTR_RST = N'(1) << (N - 1);

    logic [N-1:0]     ptr;
    logic [N-1:0]     eligible;
    logic [N-1:0]     w;
    logic [WIDTH-1:0] mux_data;
    logic             free;
    logic             load;
    logic             found;
    int               ptr_idx;
    int               idx;

`ifdef MUX1HOT_RR_ARB_PKT_LOCK_EN
    logic         locked;
    logic [N-1:0] lock_mask;
    logic         last_sel;

    // While a packet is open only its lane may compete, even if it is idle.
    assign eligible = locked ? (in_valid & lock_mask) : in_valid;
    assign last_sel = |(in_last & w);
`else
    assign eligible = in_valid;
`endif

    assign free     = !out_valid || out_ready;
    assign load     = free && (|w);
    assign in_ready = (reset_n && free) ? w : '0;

    always_comb begin
        ptr_idx = 0;
        for (int i = 0; i < N; i++) begin
            if (ptr[i]) ptr_idx = i;
        end
        w     = '0;
        found = 1'b0;
        idx   = 0;
        // Search starts just after the last loaded lane and wraps through it.
        for (int k = 1; k <= N; k++) begin
            idx = ptr_idx + k;
            if (idx >= N) idx = idx - N;
            if (!found && eligible[idx]) begin
                w[idx] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N; i++) begin
            mux_data = mux_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w[i]}});
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_grant <= '0;
            ptr       <= PTR_RST;
`ifdef MUX1HOT_RR_ARB_PKT_LOCK_EN
            out_last  <= 1'b0;
            locked    <= 1'b0;
            lock_mask <= '0;
`endif
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_grant <= w;
`ifdef MUX1HOT_RR_ARB_PKT_LOCK_EN
            out_last  <= last_sel;
            locked    <= !last_sel;
            lock_mask <= w;
            if (last_sel) ptr <= w;
`else
            ptr       <= w;
`endif
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_grant <= '0;
        end
    end

endmodule

// File: tb/tb_mux1hot_rr_arb.sv
// Directed bench for mux1hot_rr_arb (N=3, WIDTH=3); packet-lock scenario built only
// when MUX1HOT_RR_ARB_PKT_LOCK_EN is defined.
module tb_mux1hot_rr_arb;
    localparam int N = 3;
    localparam int W = 3;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [N-1:0]   out_grant;
`ifdef MUX1HOT_RR_ARB_PKT_LOCK_EN
    logic [N-1:0]   in_last;
    logic           out_last;
`endif

    int errors = 0;
    int checks = 0;
    logic [N-1:0] exp_q[$];
    logic [W-1:0] exp_d_q[$];

    mux1hot_rr_arb #(.N(N), .WIDTH(W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
`ifdef MUX1HOT_RR_ARB_PKT_LOCK_EN
        .in_last(in_last),
        .out_last(out_last),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_grant(out_grant)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 3'b111;
        out_ready = 1'b1;
        in_data   = {3'b010, 3'b001, 3'b000};
`ifdef MUX1HOT_RR_ARB_PKT_LOCK_EN
        in_last   = 3'b111;
`endif
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_grant !== 3'b000) begin errors++; $display("FAIL reset_out_grant: got %b expected 000", out_grant); end
        checks++; if (in_ready !== 3'b000) begin errors++; $display("FAIL reset_in_ready: got %b expected 000", in_ready); end
        checks++; if (out_data !== 3'b000) begin errors++; $display("FAIL reset_out_data: got %b expected 000", out_data); end
        reset_n = 1'b1;
        #1;
        checks++; if (in_ready !== 3'b001) begin errors++; $display("FAIL reset_first_ready: got %b expected 001", in_ready); end
        tick();
        checks++; if (out_grant !== 3'b001) begin errors++; $display("FAIL reset_first_grant: got %b expected 001", out_grant); end
        in_valid = 3'b000;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_single();
        reset_pulse();
        out_ready = 1'b1;
        in_data   = {3'b110, 3'b001, 3'b101};
        in_valid  = 3'b010;
        #1;
        checks++; if (in_ready !== 3'b010) begin errors++; $display("FAIL single_ready: got %b expected 010", in_ready); end
        tick();
        in_valid = 3'b000;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 3'b001) begin errors++; $display("FAIL single_data: got %b expected 001", out_data); end
        checks++; if (out_grant !== 3'b010) begin errors++; $display("FAIL single_grant: got %b expected 010", out_grant); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_grant !== 3'b000) begin errors++; $display("FAIL single_drain: got valid=%b grant=%b expected 0/000", out_valid, out_grant); end
        checks++; if (out_data !== 3'b001) begin errors++; $display("FAIL single_data_hold: got %b expected 001", out_data); end
    endtask

    task automatic test_rotation();
        reset_pulse();
        in_data   = {3'b010, 3'b001, 3'b000};
        out_ready = 1'b1;
        in_valid  = 3'b111;
        exp_q   = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_d_q = '{3'b000, 3'b001, 3'b010, 3'b000};
        while (exp_q.size() > 0) begin
            logic [N-1:0] eg;
            logic [W-1:0] ed;
            tick();
            eg = exp_q.pop_front();
            ed = exp_d_q.pop_front();
            checks++; if (out_grant !== eg || out_data !== ed || out_valid !== 1'b1) begin errors++; $display("FAIL rotation: got grant=%b data=%b valid=%b expected %b/%b/1", out_grant, out_data, out_valid, eg, ed); end
        end
        // lanes 0 and 2 only: lane 1 idle must be skipped
        in_valid = 3'b101;
        exp_q = '{3'b100, 3'b001, 3'b100};
        while (exp_q.size() > 0) begin
            logic [N-1:0] eg;
            tick();
            eg = exp_q.pop_front();
            checks++; if (out_grant !== eg) begin errors++; $display("FAIL rotation_skip: got %b expected %b", out_grant, eg); end
        end
        in_valid = 3'b000;
        tick();
    endtask

    task automatic test_backpressure();
        reset_pulse();
        in_data   = {3'b010, 3'b001, 3'b000};
        in_valid  = 3'b111;
        out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 3'b001) begin errors++; $display("FAIL bp_first_ready: got %b expected 001", in_ready); end
        tick();
        for (int c = 0; c < 4; c++) begin
            checks++; if (out_valid !== 1'b1 || out_grant !== 3'b001 || out_data !== 3'b000) begin errors++; $display("FAIL bp_hold: cycle %0d got valid=%b grant=%b data=%b expected 1/001/000", c, out_valid, out_grant, out_data); end
            checks++; if (in_ready !== 3'b000) begin errors++; $display("FAIL bp_ready: cycle %0d got %b expected 000", c, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 3'b010) begin errors++; $display("FAIL bp_release_ready: got %b expected 010", in_ready); end
        tick();
        checks++; if (out_grant !== 3'b010 || out_data !== 3'b001) begin errors++; $display("FAIL bp_next_beat: got grant=%b data=%b expected 010/001", out_grant, out_data); end
        in_valid = 3'b000;
        tick();
    endtask

    task automatic test_drop_and_idle();
        reset_pulse();
        in_data   = {3'b011, 3'b111, 3'b100};
        out_ready = 1'b0;
        in_valid  = 3'b001;
        tick();
        in_valid = 3'b010;
        tick();
        in_valid  = 3'b100;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 3'b100) begin errors++; $display("FAIL drop_ready: got %b expected 100", in_ready); end
        tick();
        checks++; if (out_grant !== 3'b100 || out_data !== 3'b011) begin errors++; $display("FAIL drop_grant: got grant=%b data=%b expected 100/011", out_grant, out_data); end
        in_valid = 3'b000;
        tick();
        tick();
        tick();
        in_valid = 3'b111;
        #1;
        checks++; if (in_ready !== 3'b001) begin errors++; $display("FAIL idle_ptr: got %b expected 001", in_ready); end
        in_valid = 3'b000;
        tick();
    endtask

    task automatic test_reset_mid();
        reset_pulse();
        in_data   = {3'b110, 3'b001, 3'b000};
        in_valid  = 3'b100;
        out_ready = 1'b0;
        tick();
        checks++; if (out_grant !== 3'b100 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_setup: got grant=%b valid=%b expected 100/1", out_grant, out_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_grant !== 3'b000 || out_data !== 3'b000) begin errors++; $display("FAIL mid_async: got valid=%b grant=%b data=%b expected 0/000/000", out_valid, out_grant, out_data); end
        checks++; if (in_ready !== 3'b000) begin errors++; $display("FAIL mid_ready: got %b expected 000", in_ready); end
        in_valid  = 3'b111;
        out_ready = 1'b1;
        tick();
        reset_n = 1'b1;
        #1;
        tick();
        checks++; if (out_grant !== 3'b001 || out_data !== 3'b000) begin errors++; $display("FAIL mid_first_grant: got grant=%b data=%b expected 001/000", out_grant, out_data); end
        in_valid = 3'b000;
        tick();
    endtask

`ifdef MUX1HOT_RR_ARB_PKT_LOCK_EN
    task automatic test_pkt_lock();
        reset_pulse();
        in_data   = {3'b111, 3'b101, 3'b010};
        in_valid  = 3'b011;
        in_last   = 3'b010;
        out_ready = 1'b1;
        tick();
        checks++; if (out_grant !== 3'b001 || out_last !== 1'b0) begin errors++; $display("FAIL lock_beat1: got grant=%b last=%b expected 001/0", out_grant, out_last); end
        tick();
        checks++; if (out_grant !== 3'b001 || out_last !== 1'b0) begin errors++; $display("FAIL lock_beat2: got grant=%b last=%b expected 001/0", out_grant, out_last); end
        in_valid = 3'b010;
        #1;
        checks++; if (in_ready !== 3'b000) begin errors++; $display("FAIL lock_idle_ready: got %b expected 000", in_ready); end
        tick();
        in_valid = 3'b011;
        in_last  = 3'b011;
        tick();
        checks++; if (out_grant !== 3'b001 || out_last !== 1'b1) begin errors++; $display("FAIL lock_beat3: got grant=%b last=%b expected 001/1", out_grant, out_last); end
        tick();
        checks++; if (out_grant !== 3'b010 || out_data !== 3'b101) begin errors++; $display("FAIL lock_next: got grant=%b data=%b expected 010/101", out_grant, out_data); end
        in_valid = 3'b000;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_drop_and_idle();
        test_reset_mid();
`ifdef MUX1HOT_RR_ARB_PKT_LOCK_EN
        test_pkt_lock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
